mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Sequences and shares the single-port data memory between the processor core's `read`/`write` strobes and a host loader port that preloads or inspects memory. The arbiter sits between the control unit's memory strobes and the memory macro. It runs each access as a fixed-latency multi-cycle transaction and returns data with a one-cycle done pulse. Core requests have priority, and a starvation counter bounds how long the host can be starved.

## Interface

Parameters:

- `DATA_W`, 16: data word width (matches AC/bus width)
- `ADDR_W`, 16: memory address width
- `MEM_LAT`, 2: cycles from the issue cycle to valid `mem_rdata`; legal range 1..15
- `MAX_WAIT`, 4: number of consecutive core grants while the host is pending before the host is forced; legal range 1..15

Ports:

- `clk`  in  1  single clock; everything is on the rising edge
- `rst`  in  1  synchronous, active-high reset
- `core_read`  in  1  core read request, level, held until `core_done`
- `core_write`  in  1  core write request, level, held until `core_done`
- `core_addr`  in  ADDR_W  core address, held with the request
- `core_wdata`  in  DATA_W  core write data
- `core_rdata`  out  DATA_W  read data, valid while `core_done`=1
- `core_done`  out  1  one-cycle completion pulse
- `host_req`  in  1  host request, level
- `host_we`  in  1  1 = write, 0 = read
- `host_addr`  in  ADDR_W  host address
- `host_wdata`  in  DATA_W  host write data
- `host_rdata`  out  DATA_W  read data, valid while `host_done`=1
- `host_done`  out  1  one-cycle completion pulse
- `mem_en`  out  1  memory access strobe
- `mem_we`  out  1  memory write enable, qualified by `mem_en`
- `mem_addr`  out  ADDR_W  memory address
- `mem_wdata`  out  DATA_W  memory write data
- `mem_rdata`  in  DATA_W  memory read data
- `busy`  out  1  high in every state except IDLE
- `grant_host`  out  1  1 while the current or last transaction is owned by the host

## Operation

- FSM states: IDLE → ISSUE → WAIT → RESP → IDLE.
- **IDLE**
  - Samples requests. A core request is `core_read|core_write`.
  - Core only pending: grant core. Host only pending: grant host.
  - Both pending: grant host if `starve_cnt` ≥ MAX_WAIT, else grant core.
  - Granting the core while `host_req`=1 increments `starve_cnt` (saturating at 15).
  - Any host grant clears `starve_cnt`.
  - The request's address, write data and direction are latched at grant.
- **ISSUE** (exactly 1 cycle)
  - `mem_en`=1; `mem_we` is the latched direction; `mem_addr`/`mem_wdata` are the latched values.
- **WAIT** (MEM_LAT cycles, down-counter)
  - `mem_en`=0.
  - `mem_rdata` is captured into the owner's rdata register on the last WAIT cycle.
- **RESP** (1 cycle)
  - The owner's done pulses. Reads present the captured data; writes leave rdata unchanged.
- Core `core_read` and `core_write` both high: executes as a write.
- Requests are not sampled outside IDLE. Deasserting a request mid-transaction does not abort it; the done pulse still fires.
- A requester must drop its request on the cycle after seeing its done pulse. A request still high in IDLE is a new transaction.
- The memory outputs (`mem_addr`/`mem_wdata`/`mem_we`) hold their last values when `mem_en`=0.

## Timing

- **Reset values:** state IDLE; `starve_cnt`=0; all outputs 0, including `core_rdata`, `host_rdata`, `mem_addr`, `mem_wdata`.
- All outputs are registered.
- **Request-to-done latency:** a request is high in IDLE cycle 0.
  - ISSUE is cycle 1, with `mem_en`=1.
  - WAIT is cycles 2..MEM_LAT+1; `mem_rdata` is sampled at the end of cycle MEM_LAT+1.
  - Done is in cycle MEM_LAT+2; with MEM_LAT=2, done is in cycle 4.
- **Throughput:** one transaction per MEM_LAT+3 cycles when requests are back-to-back.
- **Reset mid-transaction:** the next cycle is IDLE, `mem_en`=0, and no done pulse is issued for the aborted access.
- **Simultaneous arrival in IDLE:** resolved as in Operation; the loser stays pending, and no request is lost while it is held.
- **Counter saturation:** `starve_cnt` saturates at 15 and never wraps.

## Test plan

- **Reset:** assert `rst` for 2 cycles mid-ISSUE → next cycle all outputs 0, `busy`=0, no done pulse.
- **Core read:** MEM_LAT=2, `core_read`=1 at addr 0x0010, memory returns 0xBEEF → `mem_en` high in cycle 1 only, `core_done`=1 with `core_rdata`=0xBEEF in cycle 4, `host_done` stays 0.
- **Host write:** `host_req`=1, `host_we`=1, addr 0x0003, data 0x1234 → `mem_en`=`mem_we`=1 in cycle 1 with 0x0003/0x1234, `host_done` in cycle 4, `grant_host`=1.
- **Contention and starvation:** MAX_WAIT=4, core requests continuously, host held high.
  - The core wins 4 times, then the host is granted on the 5th arbitration, then the core wins again.
  - `starve_cnt` returns to 0 after the host grant.
- **Both core strobes high:** `core_read`=`core_write`=1 → `mem_we`=1 in the ISSUE cycle and `core_rdata` is unchanged at done.
- **Early drop:** `core_read` dropped during WAIT → `core_done` still pulses in cycle MEM_LAT+2, and no second transaction is issued.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Shares the single-port data memory between the core strobes and the host loader port.
// Each access runs as a fixed-latency IDLE -> ISSUE -> WAIT -> RESP transaction.
module mem_port_arbiter #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 16,
  parameter int MEM_LAT  = 2,
  parameter int MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              core_read,
  input  logic              core_write,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [DATA_W-1:0] core_wdata,
  output logic [DATA_W-1:0] core_rdata,
  output logic              core_done,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic [DATA_W-1:0] host_rdata,
  output logic              host_done,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              grant_host
);

  localparam logic [3:0] LAT_C  = 4'(MEM_LAT);
  localparam logic [3:0] WAIT_C = 4'(MAX_WAIT);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t     state, state_nxt;
  logic [3:0] wait_cnt;
  logic [3:0] starve_cnt;
  logic       core_req;
  logic       take_core;
  logic       take_host;

  function automatic logic [3:0] sat_inc(input logic [3:0] v);
    return (v == 4'd15) ? v : v + 4'd1;
  endfunction

  assign core_req = core_read | core_write;

  always_comb begin
    state_nxt = state;
    take_core = 1'b0;
    take_host = 1'b0;
    case (state)
      IDLE: begin
        if (core_req && !(host_req && (starve_cnt >= WAIT_C))) take_core = 1'b1;
        else if (host_req)                                     take_host = 1'b1;
        if (take_core || take_host) state_nxt = ISSUE;
      end
      ISSUE: state_nxt = WAIT;
      WAIT:  if (wait_cnt == 4'd1) state_nxt = RESP;
      RESP:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // The mem_* registers double as the grant-time latches and hold while mem_en is low.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      wait_cnt   <= '0;
      starve_cnt <= '0;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      core_rdata <= '0;
      host_rdata <= '0;
      core_done  <= 1'b0;
      host_done  <= 1'b0;
      busy       <= 1'b0;
      grant_host <= 1'b0;
    end else begin
      state     <= state_nxt;
      busy      <= (state_nxt != IDLE);
      mem_en    <= 1'b0;
      core_done <= 1'b0;
      host_done <= 1'b0;
      case (state)
        IDLE: begin
          if (take_host) begin
            mem_en     <= 1'b1;
            grant_host <= 1'b1;
            mem_we     <= host_we;
            mem_addr   <= host_addr;
            mem_wdata  <= host_wdata;
            starve_cnt <= '0;
          end else if (take_core) begin
            mem_en     <= 1'b1;
            grant_host <= 1'b0;
            mem_we     <= core_write;
            mem_addr   <= core_addr;
            mem_wdata  <= core_wdata;
            if (host_req) starve_cnt <= sat_inc(starve_cnt);
          end
        end
        ISSUE: wait_cnt <= LAT_C;
        WAIT: begin
          wait_cnt <= wait_cnt - 4'd1;
          if (wait_cnt == 4'd1) begin
            core_done <= !grant_host;
            host_done <= grant_host;
            if (!mem_we) begin
              if (grant_host) host_rdata <= mem_rdata;
              else            core_rdata <= mem_rdata;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomised scoreboard bench for mem_port_arbiter: a transaction-level model predicts
// grants and data, a monitor compares every memory issue, done pulse and busy flag.
module tb_mem_port_arbiter;
  localparam int DW = 16;
  localparam int AW = 16;
  localparam int LAT = 2;
  localparam int MW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          core_read, core_write, host_req, host_we;
  logic [AW-1:0] core_addr, host_addr, mem_addr;
  logic [DW-1:0] core_wdata, host_wdata, mem_wdata, mem_rdata;
  logic [DW-1:0] core_rdata, host_rdata;
  logic          core_done, host_done, mem_en, mem_we, busy, grant_host;

  typedef struct {
    bit          host;
    bit          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
    int          issue;
    int          done;
  } exp_t;

  exp_t sb[$];
  bit   glog[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  bit   exp_busy = 1'b0;
  bit   exp_zero = 1'b0;

  mem_port_arbiter #(.DATA_W(DW), .ADDR_W(AW), .MEM_LAT(LAT), .MAX_WAIT(MW)) dut (
    .clk(clk), .rst(rst),
    .core_read(core_read), .core_write(core_write), .core_addr(core_addr),
    .core_wdata(core_wdata), .core_rdata(core_rdata), .core_done(core_done),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
    .host_wdata(host_wdata), .host_rdata(host_rdata), .host_done(host_done),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy), .grant_host(grant_host)
  );

  initial forever #5 clk = ~clk;

  function automatic logic [DW-1:0] init_word(input int i);
    return (i == 0) ? 16'hBEEF : 16'((i * 16'h1357) ^ 16'hA5A5);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Memory macro: read data is valid only in the cycle the arbiter should sample it.
  initial begin
    logic [DW-1:0] bmem [16];
    logic [AW-1:0] raddr;
    int rcnt;
    for (int i = 0; i < 16; i++) bmem[i] = init_word(i);
    mem_rdata = '0;
    raddr = '0;
    rcnt = 0;
    forever begin
      @(negedge clk);
      if (mem_en && mem_we) bmem[mem_addr[3:0]] = mem_wdata;
      if (mem_en && !mem_we) begin
        raddr = mem_addr;
        rcnt = LAT + 1;
      end else if (rcnt > 0) rcnt--;
      mem_rdata = (rcnt == 1) ? bmem[raddr[3:0]] : 16'($urandom);
    end
  end

  // Reference model: one transaction every LAT+3 cycles, starvation-bounded core priority.
  initial begin
    logic [DW-1:0] rmem [16];
    logic [DW-1:0] last_c, last_h;
    int remaining, starve;
    bit creq, hw;
    exp_t e;
    for (int i = 0; i < 16; i++) rmem[i] = init_word(i);
    last_c = '0; last_h = '0; remaining = 0; starve = 0;
    forever begin
      @(posedge clk);
      cyc++;
      if (rst) begin
        sb.delete();
        remaining = 0; starve = 0; last_c = '0; last_h = '0;
        exp_zero = 1'b1;
      end else begin
        exp_zero = 1'b0;
        if (remaining == 0) begin
          creq = core_read | core_write;
          if (creq || host_req) begin
            hw = host_req && (!creq || starve >= MW);
            e.host  = hw;
            e.we    = hw ? host_we : core_write;
            e.addr  = hw ? host_addr : core_addr;
            e.wdata = hw ? host_wdata : core_wdata;
            if (e.we) begin
              rmem[e.addr[3:0]] = e.wdata;
              e.rdata = hw ? last_h : last_c;
            end else begin
              e.rdata = rmem[e.addr[3:0]];
              if (hw) last_h = e.rdata; else last_c = e.rdata;
            end
            e.issue = cyc;
            e.done  = cyc + LAT + 1;
            sb.push_back(e);
            if (hw) starve = 0;
            else if (host_req && starve < 15) starve++;
            remaining = LAT + 2;
          end
        end else remaining--;
      end
      exp_busy = (remaining > 0);
    end
  end

  // Monitor: compares everything the DUT presents against the head of the scoreboard.
  initial begin
    bit has, exp_en, exp_dn;
    forever begin
      @(negedge clk);
      if (exp_zero) begin
        check("rst_mem_bus", {30'd0, mem_en, mem_we, mem_addr, mem_wdata}, 64'd0);
        check("rst_outputs", {28'd0, core_done, host_done, busy, grant_host, core_rdata, host_rdata}, 64'd0);
      end
      check("busy", busy, exp_busy);
      has    = (sb.size() > 0);
      exp_en = has && (sb[0].issue == cyc);
      exp_dn = has && (sb[0].done == cyc);
      check("mem_en", mem_en, exp_en);
      if (mem_en) glog.push_back(grant_host);
      if (mem_en && exp_en) begin
        check("issue_owner", grant_host, sb[0].host);
        check("issue_we", mem_we, sb[0].we);
        check("issue_addr", mem_addr, sb[0].addr);
        if (sb[0].we) check("issue_wdata", mem_wdata, sb[0].wdata);
      end
      check("core_done", core_done, exp_dn && !sb[0].host);
      check("host_done", host_done, exp_dn && sb[0].host);
      if (exp_dn) begin
        check("done_owner", grant_host, sb[0].host);
        if (sb[0].host) check("host_rdata", host_rdata, sb[0].rdata);
        else            check("core_rdata", core_rdata, sb[0].rdata);
        void'(sb.pop_front());
      end
    end
  end

  // dir: 0 = read, 1 = write, 2 = both strobes
  task automatic core_txn(input int dir, input logic [AW-1:0] a, input logic [DW-1:0] d,
                          input bit drop, output int lat, output logic [DW-1:0] rd);
    bit seen, fin;
    @(posedge clk); #1;
    core_read = (dir != 1); core_write = (dir != 0); core_addr = a; core_wdata = d;
    lat = 0; seen = 0; fin = 0; rd = '0;
    while (!fin && lat < 300) begin
      @(negedge clk); lat++;
      if (core_done) begin fin = 1; rd = core_rdata; end
      else if (mem_en && !grant_host) seen = 1;
      if (drop && seen && !fin && (core_read || core_write)) begin
        @(posedge clk); #1; core_read = 0; core_write = 0;
      end
    end
    check("core_txn_completes", fin, 1'b1);
    @(posedge clk); #1; core_read = 0; core_write = 0;
  endtask

  task automatic host_txn(input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                          input bit drop, output int lat, output logic [DW-1:0] rd);
    bit seen, fin;
    @(posedge clk); #1;
    host_req = 1; host_we = we; host_addr = a; host_wdata = d;
    lat = 0; seen = 0; fin = 0; rd = '0;
    while (!fin && lat < 300) begin
      @(negedge clk); lat++;
      if (host_done) begin fin = 1; rd = host_rdata; end
      else if (mem_en && grant_host) seen = 1;
      if (drop && seen && !fin && host_req) begin
        @(posedge clk); #1; host_req = 0;
      end
    end
    check("host_txn_completes", fin, 1'b1);
    @(posedge clk); #1; host_req = 0;
  endtask

  initial begin
    #200000;
    failures++;
    $display("FAIL watchdog: simulation did not complete, checks=%0d", checks);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    int lat, base, n;
    logic [DW-1:0] rd;
    bit got;
    rst = 1; core_read = 0; core_write = 0; core_addr = '0; core_wdata = '0;
    host_req = 0; host_we = 0; host_addr = '0; host_wdata = '0;
    repeat (2) @(posedge clk); #1 rst = 0;

    core_txn(0, 16'h0010, 16'h0000, 0, lat, rd);
    check("core_read_data", rd, 16'hBEEF);
    check("core_read_latency", lat, LAT + 3);
    host_txn(1, 16'h0003, 16'h1234, 0, lat, rd);
    check("host_write_latency", lat, LAT + 3);
    host_txn(0, 16'h0003, 16'h0000, 0, lat, rd);
    check("host_readback", rd, 16'h1234);
    core_txn(2, 16'h0005, 16'h5555, 0, lat, rd);
    check("both_strobes_rdata_kept", rd, 16'hBEEF);
    core_txn(0, 16'h0007, 16'h0000, 1, lat, rd);
    check("early_drop_latency", lat, LAT + 3);
    check("early_drop_data", rd, init_word(7));

    // Core held continuously with host pending: host forced every MW+1 arbitrations.
    base = glog.size();
    @(posedge clk); #1;
    core_read = 1; core_addr = 16'h0009; host_req = 1; host_we = 0; host_addr = 16'h000A;
    repeat (11 * (LAT + 3)) @(posedge clk);
    #1 core_read = 0; host_req = 0;
    repeat (3) @(posedge clk);
    check("starve_grant_count", glog.size() - base, 11);
    for (int i = 0; i < 11; i++)
      if (base + i < glog.size())
        check($sformatf("starve_grant_%0d", i), glog[base + i], (i % (MW + 1)) == MW);

    // Reset asserted for two cycles starting mid-ISSUE.
    @(posedge clk); #1 core_read = 1; core_addr = 16'h0021;
    got = 0; n = 0;
    while (!got && n < 50) begin
      @(negedge clk); n++;
      if (mem_en) got = 1;
    end
    check("rst_issue_seen", got, 1'b1);
    rst = 1; core_read = 0;
    repeat (2) @(posedge clk); #1 rst = 0;
    repeat (LAT + 4) @(posedge clk);

    fork
      for (int i = 0; i < 30; i++) begin
        int clat;
        logic [DW-1:0] crd;
        repeat ($urandom_range(0, 3)) @(posedge clk);
        core_txn($urandom_range(0, 2), 16'($urandom), 16'($urandom), $urandom_range(0, 3) == 0, clat, crd);
      end
      for (int j = 0; j < 30; j++) begin
        int hlat;
        logic [DW-1:0] hrd;
        repeat ($urandom_range(0, 3)) @(posedge clk);
        host_txn($urandom_range(0, 1) == 1, 16'($urandom), 16'($urandom), $urandom_range(0, 3) == 0, hlat, hrd);
      end
    join
    repeat (LAT + 5) @(posedge clk);
    check("scoreboard_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
